// File: rtl/mxu_result_drain.sv
// mxu_result_drain: captures an MXU result matrix and streams it row-major over valid/ready with one pending slot
module mxu_result_drain #(
  parameter int BIT_WIDTH = 4,
  parameter int DIM = 2,
  parameter int OUT_W = 2*BIT_WIDTH,
  parameter int IDX_W = $clog2(DIM)
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic [DIM-1:0][DIM-1:0][OUT_W-1:0] in_data,
  output logic m_valid,
  input  logic m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [IDX_W-1:0] m_row,
  output logic [IDX_W-1:0] m_col,
  output logic m_last,
  output logic busy,
  output logic overflow
);
  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [DIM-1:0][DIM-1:0][OUT_W-1:0] mat_t;
  localparam logic [IDX_W-1:0] TOP = IDX_W'(DIM-1);
  state_t state, state_nx;
  mat_t act, act_nx, pend, pend_nx;
  logic pend_full, pend_full_nx, ovf_nx, last_nx, xfer, fin;
  logic [IDX_W-1:0] row_nx, col_nx;
  assign m_valid = state == STREAM;
  assign busy = m_valid | pend_full;
  assign xfer = m_valid & m_ready;
  assign fin = xfer & m_last;
  // next-state: advance the element index, retire/promote matrices, accept or drop captures
  always_comb begin
    state_nx = state;
    act_nx = act;
    pend_nx = pend;
    pend_full_nx = pend_full;
    ovf_nx = overflow;
    row_nx = m_row;
    col_nx = m_col;
    if (state == IDLE) begin
      if (in_valid) begin
        act_nx = in_data;
        row_nx = '0;
        col_nx = '0;
        state_nx = STREAM;
      end
    end else begin
      if (fin) begin
        row_nx = '0;
        col_nx = '0;
        if (pend_full) begin
          act_nx = pend;
          pend_full_nx = 1'b0;
        end else if (in_valid) act_nx = in_data;
        else state_nx = IDLE;
      end else if (xfer) begin
        col_nx = m_col == TOP ? '0 : m_col + 1'b1;
        row_nx = m_col == TOP ? m_row + 1'b1 : m_row;
      end
      if (in_valid && !(fin && !pend_full)) begin
        if (!pend_full || fin) begin
          pend_nx = in_data;
          pend_full_nx = 1'b1;
        end else ovf_nx = 1'b1;
      end
    end
    last_nx = state_nx == STREAM && row_nx == TOP && col_nx == TOP;
  end
  // control and output registers; outputs are looked up from the next-cycle buffer and index
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend_full <= 1'b0;
      overflow <= 1'b0;
      m_row <= '0;
      m_col <= '0;
      m_data <= '0;
      m_last <= 1'b0;
    end else begin
      state <= state_nx;
      pend_full <= pend_full_nx;
      overflow <= ovf_nx;
      m_row <= row_nx;
      m_col <= col_nx;
      m_data <= act_nx[row_nx][col_nx];
      m_last <= last_nx;
    end
  end
  // matrix storage needs no reset; its contents are only read while marked occupied
  always_ff @(posedge clk) begin
    act <= act_nx;
    pend <= pend_nx;
  end
endmodule

// File: tb/tb_mxu_result_drain.sv
// tb_mxu_result_drain: randomized and directed checks against a queue-based stream model
module tb_mxu_result_drain;
  typedef logic [1:0][1:0][7:0] mat_t;
  typedef struct {logic [7:0] d; int i;} elem_t;
  localparam int N = 4;
  logic clk = 0, reset = 1, in_valid = 0, m_ready = 0;
  mat_t in_data = '0;
  logic m_valid, m_last, busy, overflow;
  logic [7:0] m_data;
  logic m_row, m_col;
  int checks = 0, errors = 0, xfers = 0;
  logic ovf = 0;
  elem_t q[$];

  mxu_result_drain dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_col(m_col), .m_last(m_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic mat_t mk(input logic [7:0] a, b, c, d);
    mat_t m;
    m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
    return m;
  endfunction

  task automatic step(input logic v, input mat_t d, input logic r, input logic rst_i);
    elem_t e;
    logic ev;
    ev = q.size() > 0;
    checks += 3;
    if (m_valid !== ev) begin errors++; $display("FAIL m_valid got %b exp %b t=%0t", m_valid, ev, $time); end
    if (busy !== ev) begin errors++; $display("FAIL busy got %b exp %b t=%0t", busy, ev, $time); end
    if (overflow !== ovf) begin errors++; $display("FAIL overflow got %b exp %b t=%0t", overflow, ovf, $time); end
    if (ev) begin
      e = q[0];
      checks++;
      if ({m_data, m_row, m_col, m_last} !== {e.d, 1'(e.i / 2), 1'(e.i % 2), e.i == N-1}) begin
        errors++;
        $display("FAIL element got d=%h r=%0d c=%0d l=%b exp d=%h idx=%0d t=%0t", m_data, m_row, m_col, m_last, e.d, e.i, $time);
      end
    end
    in_valid = v; in_data = d; m_ready = r; reset = rst_i;
    @(posedge clk);
    if (rst_i) begin
      q.delete();
      ovf = 0;
    end else begin
      if (q.size() > 0 && r) begin void'(q.pop_front()); xfers++; end
      if (v) begin
        if ((q.size() + N - 1) / N < 2) for (int i = 0; i < N; i++) q.push_back('{d[i/2][i%2], i});
        else ovf = 1;
      end
    end
    @(negedge clk);
    in_valid = 0; reset = 0;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(0, '0, r, 0);
  endtask

  task automatic test_reset;
    step(0, '0, 0, 1);
    checks++;
    if ({m_valid, m_data, m_row, m_col, m_last, busy, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_vals got v=%b d=%h r=%b c=%b l=%b b=%b o=%b exp all 0", m_valid, m_data, m_row, m_col, m_last, busy, overflow);
    end
    step(1, mk(8'h11, 8'h22, 8'h33, 8'h44), 1, 1);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_wins got %b exp 0", m_valid); end
  endtask

  task automatic test_basic;
    int x0;
    x0 = xfers;
    step(1, mk(8'h6C, 8'h60, 8'hF0, 8'h0E), 1, 0);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h6C) begin errors++; $display("FAIL basic_latency got v=%b d=%h exp v=1 d=6c", m_valid, m_data); end
    idle(5, 1);
    checks++;
    if (xfers - x0 !== 4 || m_valid !== 0 || busy !== 0) begin
      errors++; $display("FAIL basic_done got xfers=%0d v=%b b=%b exp 4 0 0", xfers - x0, m_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    logic pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [10:0] saved;
    logic stall;
    int x0;
    x0 = xfers;
    step(1, mk(8'h6C, 8'h60, 8'hF0, 8'h0E), 0, 0);
    for (int i = 0; i < 7; i++) begin
      saved = {m_data, m_row, m_col, m_last};
      stall = m_valid && !pat[i];
      step(0, '0, pat[i], 0);
      if (stall) begin
        checks++;
        if ({m_data, m_row, m_col, m_last} !== saved) begin
          errors++; $display("FAIL bp_stable got %h exp %h", {m_data, m_row, m_col, m_last}, saved);
        end
      end
    end
    idle(3, 1);
    checks++;
    if (xfers - x0 !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", xfers - x0); end
  endtask

  task automatic test_pending;
    step(1, mk(8'h6C, 8'h60, 8'hF0, 8'h0E), 1, 0);
    step(0, '0, 1, 0);
    step(1, mk(8'h01, 8'h02, 8'h03, 8'h04), 1, 0);
    step(0, '0, 1, 0);
    checks++;
    if (m_data !== 8'h0E) begin errors++; $display("FAIL pend_pre got %h exp 0e", m_data); end
    step(0, '0, 1, 0);
    checks++;
    if (m_valid !== 1 || m_data !== 8'h01 || overflow !== 0) begin
      errors++; $display("FAIL pend_nogap got v=%b d=%h o=%b exp 1 01 0", m_valid, m_data, overflow);
    end
    idle(5, 1);
  endtask

  task automatic test_overflow;
    int x0;
    step(0, '0, 0, 1);
    x0 = xfers;
    step(1, mk(8'h10, 8'h11, 8'h12, 8'h13), 0, 0);
    step(1, mk(8'h20, 8'h21, 8'h22, 8'h23), 0, 0);
    step(1, mk(8'h30, 8'h31, 8'h32, 8'h33), 0, 0);
    checks++;
    if (overflow !== 1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    idle(12, 1);
    checks++;
    if (xfers - x0 !== 8 || overflow !== 1) begin
      errors++; $display("FAIL ovf_drain got xfers=%0d o=%b exp 8 1", xfers - x0, overflow);
    end
  endtask

  task automatic test_simul_last;
    step(0, '0, 0, 1);
    step(1, mk(8'h6C, 8'h60, 8'hF0, 8'h0E), 1, 0);
    idle(3, 1);
    step(1, mk(8'hAA, 8'hBB, 8'hCC, 8'hDD), 1, 0);
    checks++;
    if ({m_valid, m_data, m_row, m_col, overflow} !== {1'b1, 8'hAA, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL simul got v=%b d=%h r=%b c=%b o=%b exp 1 aa 0 0 0", m_valid, m_data, m_row, m_col, overflow);
    end
    idle(5, 1);
  endtask

  task automatic test_reset_mid;
    step(1, mk(8'h6C, 8'h60, 8'hF0, 8'h0E), 1, 0);
    step(1, mk(8'h01, 8'h02, 8'h03, 8'h04), 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    checks++;
    if ({m_valid, busy, overflow} !== 3'b000) begin
      errors++; $display("FAIL rst_mid got v=%b b=%b o=%b exp 000", m_valid, busy, overflow);
    end
    idle(6, 1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) == 0, mat_t'({$urandom, $urandom}), $urandom_range(2) != 0, $urandom_range(99) == 0);
    idle(12, 1);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_pending;
    test_overflow;
    test_simul_last;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mxu_result_drain.md
# mxu_result_drain

Receiving end of the temporal_mxu result interface. It captures the full DIM×DIM result matrix when the MXU pulses `out_valid`, then streams the elements out one per handshake in row-major order over a valid/ready port, tagged with row/column indices and a last flag. A one-matrix pending slot lets the MXU start its next product while the current matrix is still draining.

## Interface
Parameters:
- `BIT_WIDTH`, default 4: operand width of the MXU.
- `DIM`, default 2: matrix dimension; must be ≥ 2.
- `OUT_W`, default `2*BIT_WIDTH`: width of each result element.
- `IDX_W`, default `$clog2(DIM)`: row/column index width.

Ports:
- Reset is synchronous and active-high. There is one clock, `clk`, and all logic is on its rising edge.
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous active-high reset.
- `in_valid`, input, 1: single-cycle capture strobe; connects to MXU `out_valid`.
- `in_data`, input, [DIM-1:0][DIM-1:0][OUT_W-1:0]: result matrix, sampled only when `in_valid` is high.
- `m_valid`, output, 1: the output element is valid.
- `m_ready`, input, 1: the downstream consumer accepts the element.
- `m_data`, output, OUT_W: current element C[m_row][m_col].
- `m_row`, output, IDX_W: row index of the current element.
- `m_col`, output, IDX_W: column index of the current element.
- `m_last`, output, 1: high with the element at index DIM*DIM-1.
- `busy`, output, 1: high when the active slot or the pending slot is occupied.
- `overflow`, output, 1: sticky flag set when a matrix was dropped.

## Operation
- Storage:
  - Active buffer, which is being streamed.
  - Pending buffer plus its `pend_full` bit.
  - Element counter `idx`, range 0..DIM*DIM-1, with `m_row = idx / DIM` and `m_col = idx % DIM`.
- States:
  - IDLE: active buffer empty, `m_valid` = 0.
  - STREAM: active buffer full, `m_valid` = 1.
- Handshake: a transfer occurs on a cycle where `m_valid && m_ready`. When the transfer is at `idx == DIM*DIM-1`, `idx` returns to 0 and the active matrix retires.
- IDLE + `in_valid`: capture `in_data` into the active buffer, set `idx` = 0, go to STREAM.
- STREAM, non-final transfer: `idx` increments.
- STREAM, final transfer:
  - If `pend_full`: promote the pending buffer to active, clear `pend_full`, stay in STREAM. There is no bubble cycle.
  - Otherwise: go to IDLE.
- STREAM + `in_valid`:
  - If the pending slot is empty, or is being promoted this same cycle, write `in_data` into pending and set `pend_full`.
  - If the pending slot is full and not being promoted, drop `in_data` and set `overflow`. Active and pending contents are unchanged.
- Final transfer + `in_valid` with the pending slot empty: `in_data` becomes the next active matrix directly. The block stays in STREAM with `idx` = 0, and `pend_full` stays 0.
- `overflow` stays set until reset.
- No arithmetic is performed. Elements pass through bit-exact at OUT_W bits; the MXU has already wrapped its products modulo 2^OUT_W.
- Output stability: while `m_valid && !m_ready`, `m_data`, `m_row`, `m_col` and `m_last` hold their values.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `m_row` = 0, `m_col` = 0, `m_last` = 0.
  - `busy` = 0, `overflow` = 0, `pend_full` = 0, state IDLE.
  - Buffer contents are don't-care.
- Reset mid-stream discards the active and pending matrices. Outputs take their reset values on the next edge.
- Latency: `in_valid` sampled at edge t gives `m_valid` = 1 with element [0][0] after edge t, so it is visible in cycle t+1.
- Throughput: one element per cycle while `m_ready` is held high. A back-to-back matrix from the pending slot follows the last element of the previous matrix with zero idle cycles.
- `in_valid` in the same cycle as `reset`: reset wins, and the data is discarded.
- All outputs are registered; there is no combinational path from `m_ready` to `m_valid`.

## Test plan
- **Basic drain:** reset, then `in_valid` with C = {[0][0]=0x6C, [0][1]=0x60, [1][0]=0xF0, [1][1]=0x0E}, and `m_ready` = 1. Required: `m_valid` rises the next cycle; data 6C, 60, F0, 0E with (row,col) = (0,0), (0,1), (1,0), (1,1); `m_last` only with 0E; then `m_valid` = 0 and `busy` = 0.
- **Backpressure:** same matrix, with `m_ready` toggling 1,0,0,1,1,0,1. Required: exactly 4 transfers in order; `m_data` and indices are stable through every stalled cycle.
- **Pending slot:** second matrix {0x01, 0x02, 0x03, 0x04} captured while the first is at idx 1. Required: 01 follows 0E with no gap cycle; `overflow` = 0.
- **Overflow:** three captures while `m_ready` = 0. Required: `overflow` = 1; only the first two matrices are ever emitted; `overflow` stays 1 after both have drained.
- **Simultaneous last + in_valid with the pending slot empty:** `in_valid` with {0xAA, 0xBB, 0xCC, 0xDD} on the cycle 0E transfers. Required: AA appears in the next cycle at idx 0; `overflow` = 0.
- **Reset mid-stream:** assert `reset` at idx 2 with a matrix pending. Required: `m_valid` = 0, `busy` = 0 and `overflow` = 0 after the edge; the old data never reappears.
